rs_read_encoder: RTL

Serial systematic Reed-Solomon RS(15,11) encoder over GF(2^4). It is the transmit-side counterpart of the RS write decoder. It accepts 11 four-bit data symbols on a valid/ready stream and emits a 15-symbol codeword: the 11 data symbols unchanged, followed by 4 parity symbols. It sits in front of the decoder in the tile datapath and generates the codewords the decoder consumes.

---
 rtl/rs_read_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/rs_read_encoder.sv
// rs_read_encoder: serial systematic RS(15,11) encoder over GF(16), field poly x^4+x+1.
// Build macro RS_ERR_INJECT_EN adds inj_pos/inj_mask ports for single-symbol corruption.
module rs_read_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_sym,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
`ifdef RS_ERR_INJECT_EN
  ,
  input  logic [3:0] inj_pos,
  input  logic [3:0] inj_mask
`endif
);

  typedef enum logic {S_DATA, S_PARITY} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_par3, r_par2, r_par1, r_par0;
  logic [3:0] r_out_sym_p0;
  logic       r_vld_p0;
  logic       r_last_p0;

  logic       w_load;
  logic [3:0] w_fb;
  logic [3:0] w_err;

  // Constant GF(16) multiply; b is always a literal here, so this folds to XOR trees.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'd0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
    end
    return acc;
  endfunction

  assign w_load   = !r_vld_p0 || out_ready;
  assign in_ready = (r_state == S_DATA) && w_load;
  assign w_fb     = in_sym ^ r_par3;

`ifdef RS_ERR_INJECT_EN
  // cnt never exceeds 14, so inj_pos of 15 can never hit.
  assign w_err = (r_cnt == inj_pos) ? inj_mask : 4'd0;
`else
  assign w_err = 4'd0;
`endif

  assign out_sym   = r_out_sym_p0;
  assign out_valid = r_vld_p0;
  assign out_last  = r_last_p0;

  // Stage p0: output register, parity LFSR and frame sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_DATA;
      r_cnt        <= 4'd0;
      r_par3       <= 4'd0;
      r_par2       <= 4'd0;
      r_par1       <= 4'd0;
      r_par0       <= 4'd0;
      r_out_sym_p0 <= 4'd0;
      r_vld_p0     <= 1'b0;
      r_last_p0    <= 1'b0;
    end else if (w_load) begin
      case (r_state)
        S_DATA: begin
          r_last_p0 <= 1'b0;
          if (in_valid) begin
            r_out_sym_p0 <= in_sym ^ w_err;
            r_vld_p0     <= 1'b1;
            r_par3       <= r_par2 ^ gf_mul(w_fb, 4'd15);
            r_par2       <= r_par1 ^ gf_mul(w_fb, 4'd3);
            r_par1       <= r_par0 ^ gf_mul(w_fb, 4'd1);
            r_par0       <= gf_mul(w_fb, 4'd12);
            if (r_cnt == 4'd10) begin
              r_cnt   <= 4'd11;
              r_state <= S_PARITY;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_vld_p0 <= 1'b0;
          end
        end
        S_PARITY: begin
          // Shifting zeros in leaves the parity register clear for the next frame.
          r_out_sym_p0 <= r_par3 ^ w_err;
          r_vld_p0     <= 1'b1;
          r_par3       <= r_par2;
          r_par2       <= r_par1;
          r_par1       <= r_par0;
          r_par0       <= 4'd0;
          if (r_cnt == 4'd14) begin
            r_last_p0 <= 1'b1;
            r_cnt     <= 4'd0;
            r_state   <= S_DATA;
          end else begin
            r_last_p0 <= 1'b0;
            r_cnt     <= r_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
